interrupt_sequencer: RTL and testbench

//  Takes over the core datapath at an instruction boundary to service IRQ/NMI (and BRK when built in).
//  The sequence is: push PCH, PCL and P to the stack page, set the I flag, fetch the 16-bit vector, load the PC.

---
 rtl/interrupt_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//   Takes over the core datapath at an instruction boundary to service NMI/IRQ.
//   It pushes PCH, PCL and P to the stack page, sets the I flag, fetches the
//   16-bit vector and loads the PC. The decoder stalls while busy=1.
//   Optional build macro INTSEQ_BRK_EN: adds the brk_req input. BRK runs the
//   same sequence through VEC_IRQ, pushes pc_in+1 and sets B=1 in the pushed P.
module interrupt_sequencer #(
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic        irq,
    input  logic        nmi,
    input  logic        instr_boundary,
    input  logic        i_flag,
    input  logic [6:0]  status_in,
    input  logic [7:0]  sp_in,
    input  logic [15:0] pc_in,
    input  logic [7:0]  data_in,
`ifdef INTSEQ_BRK_EN
    input  logic        brk_req,
`endif
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw,
    output logic        sp_dec,
    output logic        set_i,
    output logic        pc_load,
    output logic [15:0] pc_load_value,
    output logic        irq_ack
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_P,
        VEC_LO,
        VEC_HI,
        LOAD_PC
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        nmi_prev_q;
    logic        nmi_pending_q;
    logic        nmi_rise;
    logic        vec_nmi_q;
    logic [7:0]  vec_lo_q;
    logic [7:0]  vec_hi_q;

    logic        take_hw;
    logic        take;
    logic        b_bit;
    logic [15:0] ret_pc;
    logic [15:0] vector;

    // status_in bit 4 has no storage in the PSR; B is generated here instead
    logic        unused_status_b;
    assign unused_status_b = status_in[4];

    assign nmi_rise = nmi & ~nmi_prev_q;
    assign take_hw  = nmi_pending_q | (irq & ~i_flag);
    assign vector   = vec_nmi_q ? VEC_NMI : VEC_IRQ;

`ifdef INTSEQ_BRK_EN
    logic brk_q;

    assign take   = take_hw | brk_req;
    assign b_bit  = brk_q;
    assign ret_pc = brk_q ? (pc_in + 16'd1) : pc_in;

    // BRK is remembered only when no hardware source won the takeover;
    // an NMI hijack later changes the vector but keeps B=1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            brk_q <= 1'b0;
        end else if (clk_enable && (state_q == IDLE) && instr_boundary && take) begin
            brk_q <= ~take_hw;
        end
    end
`else
    assign take   = take_hw;
    assign b_bit  = 1'b0;
    assign ret_pc = pc_in;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (clk_enable) begin
            state_q <= state_d;
        end
    end

    // next-state: one enabled cycle per state, takeover only at a boundary
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (instr_boundary && take) state_d = PUSH_PCH;
            PUSH_PCH: state_d = PUSH_PCL;
            PUSH_PCL: state_d = PUSH_P;
            PUSH_P:   state_d = VEC_LO;
            VEC_LO:   state_d = VEC_HI;
            VEC_HI:   state_d = LOAD_PC;
            LOAD_PC:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // NMI edge detector; a fresh edge in the clearing cycle keeps it pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nmi_prev_q    <= 1'b0;
            nmi_pending_q <= 1'b0;
        end else if (clk_enable) begin
            nmi_prev_q <= nmi;
            if (nmi_rise) begin
                nmi_pending_q <= 1'b1;
            end else if ((state_q == VEC_LO) && vec_nmi_q) begin
                nmi_pending_q <= 1'b0;
            end
        end
    end

    // vector select and fetched vector bytes; an edge seen in PUSH_P itself
    // still counts as arriving before PUSH_P completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_nmi_q <= 1'b0;
            vec_lo_q  <= '0;
            vec_hi_q  <= '0;
        end else if (clk_enable) begin
            case (state_q)
                PUSH_P:  vec_nmi_q <= nmi_pending_q | nmi_rise;
                VEC_LO:  vec_lo_q  <= data_in;
                VEC_HI:  vec_hi_q  <= data_in;
                default: ;
            endcase
        end
    end

    // output decode from registered state; IDLE leaves everything at reset values
    always_comb begin
        busy          = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_rw        = 1'b1;
        sp_dec        = 1'b0;
        set_i         = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        irq_ack       = 1'b0;
        case (state_q)
            PUSH_PCH: begin
                busy      = 1'b1;
                mem_addr  = {STACK_PAGE, sp_in};
                mem_wdata = ret_pc[15:8];
                mem_rw    = 1'b0;
                sp_dec    = 1'b1;
            end
            PUSH_PCL: begin
                busy      = 1'b1;
                mem_addr  = {STACK_PAGE, sp_in};
                mem_wdata = ret_pc[7:0];
                mem_rw    = 1'b0;
                sp_dec    = 1'b1;
            end
            PUSH_P: begin
                busy      = 1'b1;
                mem_addr  = {STACK_PAGE, sp_in};
                mem_wdata = {status_in[6], status_in[5], 1'b1, b_bit, status_in[3:0]};
                mem_rw    = 1'b0;
                sp_dec    = 1'b1;
            end
            VEC_LO: begin
                busy     = 1'b1;
                mem_addr = vector;
                set_i    = 1'b1;
            end
            VEC_HI: begin
                busy     = 1'b1;
                mem_addr = vector + 16'd1;
            end
            LOAD_PC: begin
                busy          = 1'b1;
                pc_load       = 1'b1;
                pc_load_value = {vec_hi_q, vec_lo_q};
`ifdef INTSEQ_BRK_EN
                irq_ack       = ~vec_nmi_q & ~brk_q;
`else
                irq_ack       = ~vec_nmi_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer
//   Directed bench for interrupt_sequencer (default build). A cycle-level model
//   of the service sequence (phase counter 0..6) predicts every output on every
//   cycle; directed scenarios pin the model with hand-computed literals.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_enable;
    logic        irq;
    logic        nmi;
    logic        instr_boundary;
    logic        i_flag;
    logic [6:0]  status_in;
    logic [7:0]  sp;
    logic [15:0] pc;
    logic [7:0]  data_in;
    logic        busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rw;
    logic        sp_dec;
    logic        set_i;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        irq_ack;

    logic tgl = 1'b0;
    logic toggle_mode = 1'b0;
    assign clk_enable = toggle_mode ? tgl : 1'b1;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // model state
    int mphase = 0;
    bit mpend = 1'b0;
    bit mprev = 1'b0;
    bit mvnmi = 1'b0;

    // observations of the DUT (used only for directed literal checks)
    int          ld_count = 0;
    int          busy_cycles = 0;
    int          seti_count = 0;
    logic [15:0] ld_val = '0;
    logic        ld_ack = 1'b0;
    logic [15:0] seti_addr = '0;
    logic [15:0] wr_addr[$];
    logic [7:0]  wr_data[$];

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'hFFFA: rom = 8'h34;
            16'hFFFB: rom = 8'h12;
            16'hFFFE: rom = 8'h00;
            16'hFFFF: rom = 8'h80;
            default:  rom = 8'hEA;
        endcase
    endfunction

    assign data_in = rom(mem_addr);

    interrupt_sequencer #(
        .VEC_NMI    (16'hFFFA),
        .VEC_IRQ    (16'hFFFE),
        .STACK_PAGE (8'h01)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_enable     (clk_enable),
        .irq            (irq),
        .nmi            (nmi),
        .instr_boundary (instr_boundary),
        .i_flag         (i_flag),
        .status_in      (status_in),
        .sp_in          (sp),
        .pc_in          (pc),
        .data_in        (data_in),
`ifdef INTSEQ_BRK_EN
        .brk_req        (1'b0),
`endif
        .busy           (busy),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rw         (mem_rw),
        .sp_dec         (sp_dec),
        .set_i          (set_i),
        .pc_load        (pc_load),
        .pc_load_value  (pc_load_value),
        .irq_ack        (irq_ack)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) tgl <= ~tgl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1..3 pushes, 4/5 vector bytes, 6 PC load
    task automatic model_step();
        bit rise;
        bit clr;
        if (rst_n && clk_enable && mphase >= 1 && mphase <= 3) sp <= sp - 8'd1;
        if (!rst_n) begin
            mphase = 0;
            mpend  = 1'b0;
            mprev  = 1'b0;
        end else if (clk_enable) begin
            rise  = nmi && !mprev;
            mprev = nmi;
            clr   = 1'b0;
            case (mphase)
                0: if (instr_boundary && (mpend || (irq && !i_flag))) mphase = 1;
                3: begin mvnmi = mpend || rise; mphase = 4; end
                4: begin clr = mvnmi; mphase = 5; end
                6: mphase = 0;
                default: mphase = mphase + 1;
            endcase
            if (rise) mpend = 1'b1;
            else if (clr) mpend = 1'b0;
        end
    endtask

    task automatic compare_cycle();
        logic [15:0] vec;
        logic [15:0] e_addr;
        logic [15:0] e_plv;
        logic [7:0]  e_wd;
        logic        e_busy, e_rw, e_spd, e_seti, e_pl, e_ack;
        vec    = mvnmi ? 16'hFFFA : 16'hFFFE;
        e_busy = (mphase != 0);
        e_addr = '0;
        e_wd   = '0;
        e_rw   = 1'b1;
        e_spd  = 1'b0;
        e_seti = 1'b0;
        e_pl   = 1'b0;
        e_plv  = '0;
        e_ack  = 1'b0;
        if (mphase >= 1 && mphase <= 3) begin
            e_addr = {8'h01, sp};
            e_rw   = 1'b0;
            e_spd  = 1'b1;
            if (mphase == 1) e_wd = pc[15:8];
            else if (mphase == 2) e_wd = pc[7:0];
            else e_wd = {status_in[6], status_in[5], 1'b1, 1'b0, status_in[3:0]};
        end else if (mphase == 4) begin
            e_addr = vec;
            e_seti = 1'b1;
        end else if (mphase == 5) begin
            e_addr = vec + 16'd1;
        end else if (mphase == 6) begin
            e_pl  = 1'b1;
            e_plv = {rom(vec + 16'd1), rom(vec)};
            e_ack = !mvnmi;
        end
        chk("busy", busy, e_busy);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_rw", mem_rw, e_rw);
        chk("sp_dec", sp_dec, e_spd);
        chk("set_i", set_i, e_seti);
        chk("pc_load", pc_load, e_pl);
        chk("pc_load_value", pc_load_value, e_plv);
        chk("irq_ack", irq_ack, e_ack);
        if (clk_enable) begin
            if (busy) busy_cycles++;
            if (!mem_rw) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end
            if (pc_load) begin
                ld_count++;
                ld_val = pc_load_value;
                ld_ack = irq_ack;
            end
            if (set_i) begin
                seti_count++;
                seti_addr = mem_addr;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 40) begin tick(); n++; end
        chk(name, busy, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin tick(); n++; end
        chk(name, busy, 1'b0);
    endtask

    task automatic run_case2(input string p);
        int w0, b0, l0, s0;
        sp = 8'hFF; pc = 16'h1234; status_in = 7'h41;
        w0 = wr_addr.size(); b0 = busy_cycles; l0 = ld_count; s0 = seti_count;
        i_flag = 1'b0; irq = 1'b1; instr_boundary = 1'b1;
        wait_busy({p, "_take"});
        irq = 1'b0; instr_boundary = 1'b0;
        wait_idle({p, "_done"});
        chk({p, "_nwr"}, wr_addr.size() - w0, 3);
        if (wr_addr.size() - w0 == 3) begin
            chk({p, "_wa0"}, wr_addr[w0],     16'h01FF);
            chk({p, "_wd0"}, wr_data[w0],     8'h12);
            chk({p, "_wa1"}, wr_addr[w0 + 1], 16'h01FE);
            chk({p, "_wd1"}, wr_data[w0 + 1], 8'h34);
            chk({p, "_wa2"}, wr_addr[w0 + 2], 16'h01FD);
            chk({p, "_wd2"}, wr_data[w0 + 2], 8'hA1);
        end
        chk({p, "_nload"}, ld_count - l0, 1);
        chk({p, "_pc"}, ld_val, 16'h8000);
        chk({p, "_ack"}, ld_ack, 1'b1);
        chk({p, "_nseti"}, seti_count - s0, 1);
        chk({p, "_seti_addr"}, seti_addr, 16'hFFFE);
        chk({p, "_latency"}, busy_cycles - b0, 6);
    endtask

    initial begin
        int l0, b0, w0;
        rst_n = 1'b0; irq = 1'b0; nmi = 1'b0; instr_boundary = 1'b0;
        i_flag = 1'b1; status_in = '0; sp = 8'hFF; pc = '0;
        fork
            forever begin @(posedge clk); model_step(); end
            forever begin @(negedge clk); if (cmp_on) compare_cycle(); end
        join_none
        tick();
        cmp_on = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_rw", mem_rw, 1'b1);
        chk("reset_addr", mem_addr, 16'h0000);

        // masked IRQ never taken
        irq = 1'b1; i_flag = 1'b1; instr_boundary = 1'b1;
        w0 = wr_addr.size(); b0 = busy_cycles;
        repeat (20) tick();
        chk("masked_writes", wr_addr.size() - w0, 0);
        chk("masked_busy", busy_cycles - b0, 0);
        irq = 1'b0; instr_boundary = 1'b0;
        tick();

        // basic IRQ service
        run_case2("irq");

        // NMI held high: one sequence only
        l0 = ld_count; b0 = busy_cycles;
        nmi = 1'b1; instr_boundary = 1'b1;
        repeat (50) tick();
        nmi = 1'b0; instr_boundary = 1'b0;
        chk("nmi_nload", ld_count - l0, 1);
        chk("nmi_pc", ld_val, 16'h1234);
        chk("nmi_ack", ld_ack, 1'b0);
        chk("nmi_busy", busy_cycles - b0, 6);
        repeat (3) tick();

        // NMI hijacks IRQ during PUSH_PCL
        l0 = ld_count;
        i_flag = 1'b0; irq = 1'b1; instr_boundary = 1'b1;
        wait_busy("hijack_take");
        irq = 1'b0; instr_boundary = 1'b0;
        tick();
        nmi = 1'b1;
        wait_idle("hijack_done");
        chk("hijack_pc", ld_val, 16'h1234);
        chk("hijack_ack", ld_ack, 1'b0);
        instr_boundary = 1'b1;
        repeat (10) tick();
        chk("hijack_cleared", ld_count - l0, 1);
        nmi = 1'b0; instr_boundary = 1'b0;
        repeat (3) tick();

        // reset in PUSH_PCL with an NMI pending
        l0 = ld_count;
        irq = 1'b1; instr_boundary = 1'b1;
        wait_busy("rst_take");
        irq = 1'b0; instr_boundary = 1'b0; nmi = 1'b1;
        tick();
        rst_n = 1'b0; nmi = 1'b0;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_rw", mem_rw, 1'b1);
        chk("rst_spdec", sp_dec, 1'b0);
        rst_n = 1'b1; instr_boundary = 1'b1; b0 = busy_cycles;
        repeat (10) tick();
        chk("rst_no_pending", busy_cycles - b0, 0);
        chk("rst_no_load", ld_count - l0, 0);
        instr_boundary = 1'b0;
        tick();

        // case 2 again with clk_enable toggling
        toggle_mode = 1'b1;
        run_case2("gated");
        toggle_mode = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
